// File: rtl/processador_pkg.sv
// Shared encodings for the parametrised multicycle processor: opcodes, FSM steps, ALU ops.
package processador_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVT  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2
    } alu_op_t;

endpackage

// File: rtl/processador_if.sv
// Run/done instruction handshake plus the observable bus and flags of the processor.
interface processador_if #(parameter int DW = 16);
    logic          run;
    logic [DW-1:0] iin;
    logic          done;
    logic [DW-1:0] bus;
    logic          z_flag;
    logic          c_flag;

    modport master (output run, iin, input done, bus, z_flag, c_flag);
    modport slave  (input run, iin, output done, bus, z_flag, c_flag);
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU: add with carry-out, subtract with unsigned borrow, bitwise AND.
module proc_alu
    import processador_pkg::*;
#(
    parameter int DW = 16
) (
    input  alu_op_t       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          carry,
    output logic          zero
);

    logic [DW:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            // The extra MSB of a zero-extended difference is set exactly when a < b.
            ALU_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            ALU_AND: begin
                result = a & b;
            end
            default: begin
                result = '0;
            end
        endcase
        zero = ~|result;
    end

endmodule

// File: rtl/processador_param.sv
// Multicycle processor: register file, A/G latches and the T0..T3 control FSM around a shared bus.
module processador_param
    import processador_pkg::*;
#(
    parameter int DW    = 16,
    parameter int NREGS = 8
) (
    input  logic          clock,
    input  logic          resetn,
    processador_if.slave  pif
);

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] g_q;
    logic          z_q, c_q;
    logic [DW-1:0] regs [NREGS];

    logic [2:0]    op, rx, ry;
    logic [DW-7:0] imm;
    logic [DW-1:0] rx_val, ry_val, bus;
    logic          done, wr_en, a_ld, g_ld;
    alu_op_t       alu_op;
    logic [DW-1:0] alu_res;
    logic          alu_carry, alu_zero;

    assign op  = ir_q[DW-1:DW-3];
    assign rx  = ir_q[DW-4:DW-6];
    assign ry  = ir_q[DW-7:DW-9];
    assign imm = ir_q[DW-7:0];

    // Indices beyond NREGS match no entry, so they read as zero.
    always_comb begin
        rx_val = '0;
        ry_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rx == 3'(i)) rx_val = regs[i];
            if (ry == 3'(i)) ry_val = regs[i];
        end
    end

    always_comb begin
        case (op)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    proc_alu #(.DW(DW)) u_alu (
        .op     (alu_op),
        .a      (a_q),
        .b      (bus),
        .result (alu_res),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        bus     = '0;
        done    = 1'b0;
        wr_en   = 1'b0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        case (state_q)
            T0: begin
                if (pif.run) state_d = T1;
            end
            T1: begin
                state_d = T0;
                done    = 1'b1;
                case (op)
                    OP_MV:   begin bus = ry_val;                     wr_en = 1'b1; end
                    OP_MVI:  begin bus = {{6{1'b0}}, imm};           wr_en = 1'b1; end
                    OP_MVT:  begin bus = {imm[DW/2-1:0], {(DW/2){1'b0}}}; wr_en = 1'b1; end
                    OP_MVNZ: begin bus = ry_val;                     wr_en = ~z_q; end
                    OP_NOP:  begin bus = '0; end
                    default: begin
                        bus     = rx_val;
                        a_ld    = 1'b1;
                        done    = 1'b0;
                        state_d = T2;
                    end
                endcase
            end
            T2: begin
                bus     = ry_val;
                g_ld    = 1'b1;
                state_d = T3;
            end
            T3: begin
                bus     = g_q;
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T0 && pif.run) ir_q <= pif.iin;
            if (a_ld) a_q <= bus;
            if (g_ld) begin
                g_q <= alu_res;
                z_q <= alu_zero;
                c_q <= alu_carry;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en && rx == 3'(i)) regs[i] <= bus;
            end
        end
    end

    assign pif.done   = done;
    assign pif.bus    = bus;
    assign pif.z_flag = z_q;
    assign pif.c_flag = c_q;

endmodule

// File: tb/tb_processador_param.sv
// Scoreboard bench: issuing an instruction queues its expected done-cycle bus and flags.
module tb_processador_param;
    import processador_pkg::*;

    typedef struct {
        string       tag;
        logic [15:0] bus;
        logic        z;
        logic        c;
    } exp_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clock = ~clock;

    processador_if #(.DW(16)) pa ();
    processador_if #(.DW(16)) pb ();

    processador_param #(.DW(16), .NREGS(8)) dut_a (.clock(clock), .resetn(resetn), .pif(pa));
    processador_param #(.DW(16), .NREGS(4)) dut_b (.clock(clock), .resetn(resetn), .pif(pb));

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {op, rx, ry, 7'b0};
    endfunction

    function automatic logic [15:0] enci(input logic [2:0] op, input logic [2:0] rx, input logic [9:0] imm);
        return {op, rx, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cmp_entry(input exp_t e, input logic [15:0] bus, input logic z, input logic c);
        tests++;
        if (bus !== e.bus || z !== e.z || c !== e.c) begin
            fails++;
            $display("FAIL %s: got bus=0x%04h z=%0b c=%0b, expected bus=0x%04h z=%0b c=%0b",
                     e.tag, bus, z, c, e.bus, e.z, e.c);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (pa.done) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done_a: got bus=0x%04h, expected no done", pa.bus);
            end else begin
                cmp_entry(qa.pop_front(), pa.bus, pa.z_flag, pa.c_flag);
            end
        end
        if (pb.done) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done_b: got bus=0x%04h, expected no done", pb.bus);
            end else begin
                cmp_entry(qb.pop_front(), pb.bus, pb.z_flag, pb.c_flag);
            end
        end
    end

    task automatic issue(input bit sel, input string tag, input logic [15:0] instr,
                         input logic [15:0] eb, input logic ez, input logic ec);
        exp_t e;
        logic got;
        e.tag = tag; e.bus = eb; e.z = ez; e.c = ec;
        @(negedge clock);
        if (sel) begin qb.push_back(e); pb.run = 1'b1; pb.iin = instr; end
        else     begin qa.push_back(e); pa.run = 1'b1; pa.iin = instr; end
        @(posedge clock);
        #1;
        pa.run = 1'b0;
        pb.run = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clock);
            got = sel ? pb.done : pa.done;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no done within 8 cycles, expected done", tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        pa.run = 1'b0; pa.iin = '0;
        pb.run = 1'b0; pb.iin = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        check("reset_bus",  pa.bus, 16'h0000);
        check("reset_done", {15'b0, pa.done}, 16'h0000);
        check("reset_z",    {15'b0, pa.z_flag}, 16'h0000);
        check("reset_c",    {15'b0, pa.c_flag}, 16'h0000);

        issue(0, "mv_r0_r3",    enc(OP_MV, 3'd0, 3'd3),          16'h0000, 0, 0);
        issue(0, "mvi_r4",      16'b001_100_1111110000,          16'h03F0, 0, 0);
        issue(0, "mv_r0_r4",    enc(OP_MV, 3'd0, 3'd4),          16'h03F0, 0, 0);
        issue(0, "mvi_r5",      enci(OP_MVI, 3'd5, 10'h0FF),     16'h00FF, 0, 0);
        issue(0, "add_r4_r5",   enc(OP_ADD, 3'd4, 3'd5),         16'h04EF, 0, 0);
        issue(0, "mv_r0_r4b",   enc(OP_MV, 3'd0, 3'd4),          16'h04EF, 0, 0);
        issue(0, "mvt_r0",      enci(OP_MVT, 3'd0, 10'h0FF),     16'hFF00, 0, 0);
        issue(0, "mvi_r1",      enci(OP_MVI, 3'd1, 10'h100),     16'h0100, 0, 0);
        issue(0, "add_wrap",    enc(OP_ADD, 3'd0, 3'd1),         16'h0000, 1, 1);
        issue(0, "mvnz_skip",   enc(OP_MVNZ, 3'd2, 3'd1),        16'h0100, 1, 1);
        issue(0, "mv_r3_r2",    enc(OP_MV, 3'd3, 3'd2),          16'h0000, 1, 1);
        issue(0, "sub_r1_r0",   enc(OP_SUB, 3'd1, 3'd0),         16'h0100, 0, 0);
        issue(0, "mvnz_take",   enc(OP_MVNZ, 3'd2, 3'd1),        16'h0100, 0, 0);
        issue(0, "mv_r3_r2b",   enc(OP_MV, 3'd3, 3'd2),          16'h0100, 0, 0);
        issue(0, "and_r4_r5",   enc(OP_AND, 3'd4, 3'd5),         16'h00EF, 0, 0);
        issue(0, "sub_borrow",  enc(OP_SUB, 3'd0, 3'd5),         16'hFF01, 0, 1);
        issue(0, "and_clr_c",   enc(OP_AND, 3'd0, 3'd3),         16'h0100, 0, 0);
        issue(0, "nop",         enc(OP_NOP, 3'd0, 3'd0),         16'h0000, 0, 0);

        // ADD R4,R5 aborted by reset while in T2: no done, R4 cleared.
        @(negedge clock);
        pa.run = 1'b1; pa.iin = enc(OP_ADD, 3'd4, 3'd5);
        @(posedge clock);
        #1 pa.run = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("abort_bus",  pa.bus, 16'h0000);
        check("abort_done", {15'b0, pa.done}, 16'h0000);
        issue(0, "abort_r4",    enc(OP_MV, 3'd0, 3'd4),          16'h0000, 0, 0);

        issue(1, "b_mvi_r6",    enci(OP_MVI, 3'd6, 10'd5),       16'h0005, 0, 0);
        issue(1, "b_mv_r0_r6",  enc(OP_MV, 3'd0, 3'd6),          16'h0000, 0, 0);
        issue(1, "b_mvi_r3",    enci(OP_MVI, 3'd3, 10'h2A5),     16'h02A5, 0, 0);
        issue(1, "b_mv_r1_r3",  enc(OP_MV, 3'd1, 3'd3),          16'h02A5, 0, 0);

        // run held high with NOPs: done on every second cycle.
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.tag = "b_b2b_nop"; e.bus = 16'h0000; e.z = 1'b0; e.c = 1'b0;
            qb.push_back(e);
        end
        @(negedge clock);
        pb.run = 1'b1; pb.iin = enc(OP_NOP, 3'd0, 3'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            check("b2b_done", {15'b0, pb.done}, {15'b0, (k % 2 == 1)});
            if (k == 7) pb.run = 1'b0;
        end

        repeat (3) @(negedge clock);
        check("queue_a_empty", 16'(qa.size()), 16'h0000);
        check("queue_b_empty", 16'(qb.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
